// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch: one outstanding imem request feeding a DEPTH-entry prefetch FIFO; 1-cycle gnt->req turnaround, stops requesting when the FIFO would be full.
// Optional macro FETCH_STATS_EN adds a saturating stall_cnt output (fetch_en && instr_ready && !instr_valid).
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, issued_pc;
  logic [31:0] mem_code [DEPTH];
  logic [31:0] mem_pc   [DEPTH];
  ptr_t        rd_ptr, wr_ptr;
  cnt_t        count, count_nxt;
  logic        push, pop, can_fetch;

  assign instr_valid = (count != '0);
  assign instr_code  = instr_valid ? mem_code[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]   : '0;
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;

  // Redirect outranks both FIFO operations: the flush wins over a same-cycle pop or push.
  assign pop  = instr_valid && instr_ready && !redirect;
  assign push = (state == WAIT) && imem_rvalid && !redirect && ((count != DEPTH_C) || pop);

  always_comb begin
    count_nxt = count;
    if (redirect)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + cnt_t'(1);
    else if (pop && !push)
      count_nxt = count - cnt_t'(1);
  end

  // Free-slot test uses end-of-cycle occupancy so a response filling the last slot never leaves a request parked.
  assign can_fetch = fetch_en && (count_nxt < DEPTH_C);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE: if (can_fetch) state_nxt = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_nxt = redirect ? DROP : WAIT;
          pc_nxt    = pc + 32'd4;
        end
      end
      WAIT: begin
        if (redirect)
          state_nxt = imem_rvalid ? (can_fetch ? REQ : IDLE) : DROP;
        else if (imem_rvalid)
          state_nxt = can_fetch ? REQ : IDLE;
      end
      DROP: if (imem_rvalid) state_nxt = can_fetch ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirect) pc_nxt = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      issued_pc    <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      count        <= count_nxt;
      misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
      if ((state == REQ) && imem_gnt) issued_pc <= pc;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // Storage needs no reset: the head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= issued_pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (fetch_en && instr_ready && !instr_valid && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench for instr_fetch_ctrl: the bench plays instruction memory and keeps an epoch-tagged queue model of delivered words.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0, rst_n = 1'b0, fetch_en = 1'b0, imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic        imem_req, instr_valid, misalign_err;
  logic [31:0] imem_addr, instr_code, instr_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] exp_stall;
`endif

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_code(instr_code), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
`ifdef FETCH_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] code; } ent_t;

  int          checks = 0, failures = 0;
  ent_t        q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];
  logic        pending, exp_mis, prev_req_wait, prev_redir;
  logic [31:0] pend_pc, model_pc, prev_addr;
  int          pend_epoch, epoch, lat_cnt;
  int          gnt_pct = 100, max_lat = 0, fixed_lat = -1, spur_pct = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    q.delete(); gnt_log.delete(); pop_log.delete();
    pending = 1'b0; exp_mis = 1'b0; prev_req_wait = 1'b0; prev_redir = 1'b0;
    model_pc = RESET_PC; prev_addr = '0; epoch = 0; pend_epoch = 0; lat_cnt = 0;
`ifdef FETCH_STATS_EN
    exp_stall = '0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: called at a negedge with the control inputs already set.
  task automatic tick();
    logic grant, rsp, ev;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    rsp = 1'b0;
    if (pending && lat_cnt == 0) begin
      imem_rvalid = 1'b1; imem_rdata = rom(pend_pc); rsp = 1'b1;
    end else begin
      imem_rvalid = !pending && ($urandom_range(99) < spur_pct);
      imem_rdata  = $urandom;
      if (pending) lat_cnt--;
    end
    #1;
    ev = (q.size() != 0);
    checks++;
    if (instr_valid !== ev) begin
      failures++; $display("FAIL instr_valid: got %b want %b", instr_valid, ev);
    end
    if (ev) begin
      checks++;
      if (instr_pc !== q[0].pc || instr_code !== q[0].code) begin
        failures++;
        $display("FAIL head: got pc=%h code=%h want pc=%h code=%h", instr_pc, instr_code, q[0].pc, q[0].code);
      end
    end
    checks++;
    if (misalign_err !== exp_mis) begin
      failures++; $display("FAIL misalign_err: got %b want %b", misalign_err, exp_mis);
    end
    checks++;
    if (imem_addr[1:0] !== 2'b00) begin
      failures++; $display("FAIL addr_align: got %h", imem_addr);
    end
    if (prev_req_wait) begin
      checks++;
      if (imem_req !== 1'b1 || (!prev_redir && imem_addr !== prev_addr)) begin
        failures++;
        $display("FAIL req_hold: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, prev_addr);
      end
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (stall_cnt !== exp_stall) begin
      failures++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
    end
    if (fetch_en && instr_ready && !ev && exp_stall != 32'hFFFF_FFFF) exp_stall++;
`endif
    grant = imem_req && imem_gnt;
    if (grant) begin
      checks++;
      if (imem_addr !== model_pc || pending) begin
        failures++;
        $display("FAIL grant: got addr=%h outstanding=%b want addr=%h outstanding=0", imem_addr, pending, model_pc);
      end
    end
    if (ev && instr_ready && !redirect) begin
      pop_log.push_back(q[0].pc);
      void'(q.pop_front());
    end
    if (rsp) begin
      pending = 1'b0;
      if (pend_epoch == epoch && !redirect) q.push_back('{pc: pend_pc, code: rom(pend_pc)});
    end
    if (grant) begin
      pending = 1'b1; pend_pc = model_pc; pend_epoch = epoch;
      lat_cnt = (fixed_lat >= 0) ? fixed_lat : $urandom_range(max_lat);
      gnt_log.push_back(imem_addr);
      model_pc = model_pc + 32'd4;
    end
    if (redirect) begin
      q.delete();
      epoch++;
      model_pc = {redirect_pc[31:2], 2'b00};
      exp_mis = (redirect_pc[1:0] != 2'b00);
    end else begin
      exp_mis = 1'b0;
    end
    prev_req_wait = imem_req && !imem_gnt;
    prev_addr = imem_addr;
    prev_redir = redirect;
    @(negedge clk);
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 30 && !pending; i++) tick();
    checks++;
    if (!pending) begin
      failures++; $display("FAIL wait_grant: got no grant within 30 cycles want one");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0 ||
        instr_code !== 32'h0 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b valid=%b mis=%b code=%h pc=%h want all 0",
               imem_req, instr_valid, misalign_err, instr_code, instr_pc);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    gnt_pct = 100; fixed_lat = 0; spur_pct = 0;
    fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
      failures++;
      $display("FAIL seq_pc: got %0d pops first=%h want 0,4,8", pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 32'hX);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    gnt_pct = 100; fixed_lat = 0; spur_pct = 0;
    fetch_en = 1'b1; instr_ready = 1'b0;
    repeat (10) tick();
    checks++;
    if (imem_req !== 1'b0 || gnt_log.size() != DEPTH || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL full_stall: got req=%b grants=%0d valid=%b pc=%h want req=0 grants=%0d valid=1 pc=0",
               imem_req, gnt_log.size(), instr_valid, instr_pc, DEPTH);
    end
    instr_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
      failures++; $display("FAIL drain_order: got %0d pops want 0 then 4", pop_log.size());
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    gnt_pct = 100; fixed_lat = 3; spur_pct = 0;
    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_grant();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    repeat (12) tick();
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h40) begin
      failures++;
      $display("FAIL drop_late: got %0d pops first=%h want first 40", pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 32'hX);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    gnt_pct = 100; fixed_lat = 0; spur_pct = 0;
    fetch_en = 1'b1; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect = 1'b0;
    checks++;
    if (misalign_err !== 1'b1) begin
      failures++; $display("FAIL misalign_pulse: got %b want 1", misalign_err);
    end
    tick();
    checks++;
    if (misalign_err !== 1'b0) begin
      failures++; $display("FAIL misalign_clear: got %b want 0", misalign_err);
    end
    repeat (4) tick();
    checks++;
    if (gnt_log.size() == 0 || gnt_log[0] !== 32'h20) begin
      failures++; $display("FAIL misalign_target: got %0d grants want first 20", gnt_log.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_pct = 100; fixed_lat = 0; spur_pct = 0;
    fetch_en = 1'b1; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    repeat (8) tick();
    checks++;
    if (gnt_log.size() < 2 || gnt_log[0] !== 32'hFFFF_FFFC || gnt_log[1] !== 32'h0) begin
      failures++; $display("FAIL pc_wrap: got %0d grants want FFFFFFFC then 0", gnt_log.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    gnt_pct = 100; fixed_lat = 5; spur_pct = 0;
    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_grant();
    rst_n = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; imem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL reset_mid_hold: got valid=%b req=%b want 0 0", instr_valid, imem_req);
    end
    imem_rvalid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    fixed_lat = 0;
    repeat (6) tick();
    checks++;
    if (gnt_log.size() == 0 || gnt_log[0] !== RESET_PC) begin
      failures++; $display("FAIL reset_mid_restart: got %0d grants want first %h", gnt_log.size(), RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] rp;
    do_reset();
    gnt_pct = 60; fixed_lat = -1; max_lat = 4; spur_pct = 10;
    for (int i = 0; i < 4000; i++) begin
      fetch_en    = ($urandom_range(99) < 90);
      instr_ready = ($urandom_range(99) < 60);
      redirect    = ($urandom_range(99) < 4);
      rp = $urandom;
      if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(7) == 0) rp = 32'hFFFF_FFF0 | {28'h0, rp[3:0]};
      redirect_pc = rp;
      tick();
    end
    redirect = 1'b0;
    checks++;
    if (gnt_log.size() < 200) begin
      failures++; $display("FAIL random_progress: got %0d grants want at least 200", gnt_log.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
